// File: rtl/qspi_flash_resp.sv
// QSPI flash responder: oversampled serial front end, opcode decoder and byte array.
// Optional macro QSPI_RESP_WIP_EN holds WIP set for PROG_BUSY_CYCLES after a program.
module qspi_flash_resp #(
  parameter int MEM_AW           = 16,
  parameter int DUMMY_QUAD       = 6,
  parameter int DUMMY_SINGLE     = 8,
  parameter int PROG_BUSY_CYCLES = 64
) (
  input  logic              h_clk,
  input  logic              h_rstn,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic              busy_out,
  output logic              addr4b_mode_out,
  output logic              cmd_err_out,
  input  logic              bd_wr_en,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [7:0]        bd_wdata
);
  localparam logic [2:0] S_IDLE  = 3'd0, S_CMD  = 3'd1, S_ADDR = 3'd2, S_DUMMY = 3'd3,
                         S_RD    = 3'd4, S_WR   = 3'd5, S_STAT = 3'd6, S_IGN   = 3'd7;

  // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
  logic [2:0] sclk_q, cs_q;
  logic [3:0] io_s1_q, io_s2_q;

  always_ff @(posedge h_clk or negedge h_rstn)
    if (!h_rstn) begin
      sclk_q  <= '0;
      cs_q    <= '1;
      io_s1_q <= '0;
      io_s2_q <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk_in};
      cs_q    <= {cs_q[1:0], cs_n_in};
      io_s1_q <= io_in;
      io_s2_q <= io_s1_q;
    end

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  assign sck_rise = sclk_q[1] & ~sclk_q[2];
  assign sck_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, sh_q, sh_d, dout_q, dout_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, aquad_q, aquad_d, dquad_q, dquad_d, a32_q, a32_d;
  logic              wel_q, wel_d, a4b_q, a4b_d, wr_any_q, wr_any_d, err_q, err_d;
  logic [3:0]        io_out_q, io_out_d, io_oe_q, io_oe_d;
  logic              wip, pwr;
  logic [7:0]        opc, wbyte, obyte, a_last, d_last;
  logic [7:0]        mem [2**MEM_AW];

`ifdef QSPI_RESP_WIP_EN
  localparam int WW = $clog2(PROG_BUSY_CYCLES + 1);
  logic [WW-1:0] wip_cnt_q, wip_cnt_d;
  always_comb begin
    wip_cnt_d = wip_cnt_q;
    if (cs_rise && wr_any_q)  wip_cnt_d = WW'(PROG_BUSY_CYCLES);
    else if (wip_cnt_q != '0) wip_cnt_d = wip_cnt_q - 1'b1;
  end
  always_ff @(posedge h_clk or negedge h_rstn)
    if (!h_rstn) wip_cnt_q <= '0;
    else         wip_cnt_q <= wip_cnt_d;
  assign wip = (wip_cnt_q != '0);
`else
  assign wip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;  cnt_d   = cnt_q;   sh_d    = sh_q;    dout_d   = dout_q;
    addr_d   = addr_q;   rd_d    = rd_q;    aquad_d = aquad_q; dquad_d  = dquad_q;
    a32_d    = a32_q;    wel_d   = wel_q;   a4b_d   = a4b_q;   wr_any_d = wr_any_q;
    io_out_d = io_out_q; io_oe_d = io_oe_q; err_d   = 1'b0;    pwr      = 1'b0;
    opc    = {sh_q[6:0], io_s2_q[0]};
    wbyte  = dquad_q ? {sh_q[3:0], io_s2_q} : {sh_q[6:0], io_s2_q[0]};
    obyte  = dout_q;
    a_last = aquad_q ? (a32_q ? 8'd7 : 8'd5) : (a32_q ? 8'd31 : 8'd23);
    d_last = aquad_q ? 8'(DUMMY_QUAD - 1) : 8'(DUMMY_SINGLE - 1);
    if (cs_rise) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      io_oe_d  = '0;
      io_out_d = '0;
      if (wr_any_q) wel_d = 1'b0;
      wr_any_d = 1'b0;
    end else if (cs_fall) begin
      state_d = S_CMD;
      cnt_d   = '0;
      io_oe_d = '0;
    end else begin
      case (state_q)
        S_CMD: if (sck_rise) begin
          sh_d  = opc;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d  = '0;
            addr_d = '0;
            case (opc)
              8'hB7: begin a4b_d = 1'b1; state_d = S_IDLE; end
              8'hE9: begin a4b_d = 1'b0; state_d = S_IDLE; end
              8'h06: begin wel_d = 1'b1; state_d = S_IDLE; end
              8'h05: state_d = S_STAT;
              8'h0B, 8'h0C, 8'hEB, 8'hEC, 8'h02, 8'h32, 8'h12, 8'h34: begin
                rd_d    = (opc == 8'h0B) || (opc == 8'h0C) || (opc == 8'hEB) || (opc == 8'hEC);
                aquad_d = (opc == 8'hEB) || (opc == 8'hEC);
                dquad_d = aquad_d || (opc == 8'h32) || (opc == 8'h34);
                a32_d   = a4b_q || (opc == 8'h0C) || (opc == 8'hEC) || (opc == 8'h12) || (opc == 8'h34);
                state_d = wip ? S_IGN : S_ADDR;
              end
              default: begin err_d = 1'b1; state_d = S_IGN; end
            endcase
          end
        end
        S_ADDR: if (sck_rise) begin
          // shifting past MEM_AW drops the ignored upper flash address bits
          addr_d = aquad_q ? {addr_q[MEM_AW-5:0], io_s2_q} : {addr_q[MEM_AW-2:0], io_s2_q[0]};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == a_last) begin
            cnt_d   = '0;
            state_d = rd_q ? S_DUMMY : S_WR;
          end
        end
        S_DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == d_last) begin
            cnt_d   = '0;
            state_d = S_RD;
          end
        end
        S_RD, S_STAT: if (sck_fall) begin
          io_oe_d = (state_q == S_RD && dquad_q) ? 4'b1111 : 4'b0010;
          if (cnt_q == 8'd0) begin
            obyte = (state_q == S_STAT) ? {6'b0, wel_q, wip} : mem[addr_q];
            if (state_q == S_RD) addr_d = addr_q + 1'b1;
          end
          if (state_q == S_RD && dquad_q) begin
            io_out_d = obyte[7:4];
            dout_d   = {obyte[3:0], 4'b0};
            cnt_d    = (cnt_q == 8'd1) ? 8'd0 : 8'd1;
          end else begin
            io_out_d = {2'b0, obyte[7], 1'b0};
            dout_d   = {obyte[6:0], 1'b0};
            cnt_d    = (cnt_q == 8'd7) ? 8'd0 : cnt_q + 8'd1;
          end
        end
        S_WR: if (sck_rise) begin
          sh_d  = wbyte;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == (dquad_q ? 8'd1 : 8'd7)) begin
            cnt_d = '0;
            if (wel_q) begin
              pwr      = 1'b1;
              wr_any_d = 1'b1;
              addr_d   = {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge h_clk or negedge h_rstn)
    if (!h_rstn) begin
      state_q <= S_IDLE; cnt_q <= '0; sh_q <= '0; dout_q <= '0; addr_q <= '0;
      rd_q <= 1'b0; aquad_q <= 1'b0; dquad_q <= 1'b0; a32_q <= 1'b0;
      wel_q <= 1'b0; a4b_q <= 1'b0; wr_any_q <= 1'b0; err_q <= 1'b0;
      io_out_q <= '0; io_oe_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; sh_q <= sh_d; dout_q <= dout_d; addr_q <= addr_d;
      rd_q <= rd_d; aquad_q <= aquad_d; dquad_q <= dquad_d; a32_q <= a32_d;
      wel_q <= wel_d; a4b_q <= a4b_d; wr_any_q <= wr_any_d; err_q <= err_d;
      io_out_q <= io_out_d; io_oe_q <= io_oe_d;
    end

  // backdoor preload wins over a program byte landing in the same cycle
  always_ff @(posedge h_clk)
    if (bd_wr_en) mem[bd_addr] <= bd_wdata;
    else if (pwr) mem[addr_q]  <= wbyte;

  assign io_out          = io_out_q;
  assign io_oe           = io_oe_q;
  assign busy_out        = ~cs_q[1];
  assign addr4b_mode_out = a4b_q;
  assign cmd_err_out     = err_q;
endmodule

// File: tb/tb_qspi_flash_resp.sv
// Randomized bench for qspi_flash_resp: drives sclk/cs/io as a mode-0 controller and
// checks every returned byte and flag against a byte-array/flag reference model.
module tb_qspi_flash_resp;
  localparam int AW   = 16;
  localparam int HALF = 40;

  logic          h_clk = 1'b0, h_rstn = 1'b0, sclk_in = 1'b0, cs_n_in = 1'b1;
  logic [3:0]    io_in = '0, io_out, io_oe;
  logic          busy_out, addr4b_mode_out, cmd_err_out;
  logic          bd_wr_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_wdata = '0;

  qspi_flash_resp dut (
    .h_clk(h_clk), .h_rstn(h_rstn), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .busy_out(busy_out),
    .addr4b_mode_out(addr4b_mode_out), .cmd_err_out(cmd_err_out),
    .bd_wr_en(bd_wr_en), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  always #5 h_clk = ~h_clk;

  int   checks = 0, errors = 0, err_pulses = 0;
  logic [7:0] mem_m [0:65535];
  logic       wel_m = 1'b0, a4b_m = 1'b0;

  always @(negedge h_clk) if (cmd_err_out) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge h_clk);
  endtask

  // one sclk period: drive io while low, sample DUT just before the rise
  task automatic cyc(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    io_in = din;
    #(HALF);
    dout = io_out;
    oe   = io_oe;
    sclk_in = 1'b1;
    #(HALF);
    sclk_in = 1'b0;
  endtask

  task automatic cs_lo;
    @(negedge h_clk);
    cs_n_in = 1'b0;
    clk_n(6);
  endtask

  task automatic cs_hi;
    clk_n(6);
    cs_n_in = 1'b1;
    clk_n(8);
  endtask

  task automatic bd_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge h_clk);
    bd_wr_en = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge h_clk);
    bd_wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic [3:0] d, o;
    for (int i = 7; i >= 0; i--) cyc({3'b0, b[i]}, d, o);
  endtask

  task automatic tx_addr(input logic [31:0] a, input bit quad, input bit a32);
    logic [3:0] d, o;
    int nb;
    nb = a32 ? 32 : 24;
    if (quad) for (int i = nb / 4 - 1; i >= 0; i--) cyc(a[i*4 +: 4], d, o);
    else      for (int i = nb - 1; i >= 0; i--) cyc({3'b0, a[i]}, d, o);
  endtask

  task automatic rx_byte(input bit quad, output logic [7:0] b, output logic [7:0] oe2);
    logic [3:0] d, o, oa, oo;
    b = '0; oa = 4'hF; oo = 4'h0;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      cyc(4'h0, d, o);
      b  = quad ? {b[3:0], d} : {b[6:0], d[1]};
      oa = oa & o;
      oo = oo | o;
    end
    oe2 = {oa, oo};
  endtask

  task automatic do_simple(input logic [7:0] op);
    cs_lo; tx_byte(op); cs_hi;
    if (op == 8'hB7) a4b_m = 1'b1;
    if (op == 8'hE9) a4b_m = 1'b0;
    if (op == 8'h06) wel_m = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] op, input logic [31:0] addr, input int n);
    logic [3:0] d, o;
    logic [7:0] b, oe2;
    bit quad, a32;
    quad = (op == 8'hEB) || (op == 8'hEC);
    a32  = a4b_m || (op == 8'h0C) || (op == 8'hEC);
    cs_lo; tx_byte(op); tx_addr(addr, quad, a32);
    repeat (quad ? 6 : 8) cyc(4'h0, d, o);
    for (int i = 0; i < n; i++) begin
      rx_byte(quad, b, oe2);
      chk($sformatf("rd%02h@%h+%0d", op, addr, i), {oe2, b},
          {(quad ? 8'hFF : 8'h22), mem_m[16'(addr + i)]});
    end
    cs_hi;
  endtask

  // data byte i is data[8*i +: 8]
  task automatic do_prog(input logic [7:0] op, input logic [31:0] addr, input int n,
                         input logic [31:0] data);
    logic [3:0] d, o;
    logic [7:0] b;
    bit quad, a32;
    quad = (op == 8'h32) || (op == 8'h34);
    a32  = a4b_m || (op == 8'h12) || (op == 8'h34);
    cs_lo; tx_byte(op); tx_addr(addr, 1'b0, a32);
    for (int i = 0; i < n; i++) begin
      b = data[8*i +: 8];
      if (quad) begin cyc(b[7:4], d, o); cyc(b[3:0], d, o); end
      else tx_byte(b);
      if (wel_m) mem_m[{addr[15:8], 8'(addr[7:0] + i)}] = b;
    end
    cs_hi;
    if (wel_m && n > 0) wel_m = 1'b0;
  endtask

  task automatic do_status(input int n);
    logic [7:0] b, oe2;
    cs_lo; tx_byte(8'h05);
    for (int i = 0; i < n; i++) begin
      rx_byte(1'b0, b, oe2);
      chk("status", {oe2, b}, {8'h22, 6'b0, wel_m, 1'b0});
    end
    cs_hi;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  d, o, oe_or;
    logic [31:0] r, a;
    logic [7:0]  op;
    int          e0, kind;

    clk_n(3);
    chk("reset", {io_out, io_oe, busy_out, addr4b_mode_out, cmd_err_out}, '0);
    h_rstn = 1'b1;
    clk_n(3);

    for (int i = 0; i < 512; i++) bd_wr(AW'(i), 8'($urandom));
    bd_wr(16'h0100, 8'hA1); bd_wr(16'h0101, 8'hB2);
    bd_wr(16'h0102, 8'hC3); bd_wr(16'h0103, 8'hD4);

    do_read(8'hEB, 32'h0000_0100, 4);

    do_simple(8'hB7);
    chk("addr4b_set", addr4b_mode_out, 1);
    do_read(8'hEC, 32'h0000_0100, 4);
    do_simple(8'hE9);
    chk("addr4b_clr", addr4b_mode_out, 0);

    // programmed bytes wrap inside page 0x00
    do_simple(8'h06);
    do_status(1);
    do_prog(8'h02, 32'h0000_00FE, 3, 32'h0033_2211);
    chk("pw_model", {mem_m[16'h00FE], mem_m[16'h00FF], mem_m[16'h0000]}, 32'h0011_2233);
    do_read(8'h0B, 32'h0000_00FE, 2);
    do_read(8'h0B, 32'h0000_0000, 1);
    do_status(2);

    // no WEL: program silently dropped
    do_prog(8'h02, 32'h0000_0010, 2, 32'h0000_5A5A);
    do_read(8'h0B, 32'h0000_0010, 2);
    do_status(1);

    e0 = err_pulses;
    oe_or = '0;
    cs_lo; tx_byte(8'h9F);
    repeat (16) begin cyc(4'hF, d, o); oe_or = oe_or | o; end
    cs_hi;
    chk("err_pulse", err_pulses - e0, 1);
    chk("err_oe", oe_or, 0);

    // abort a single read after 3 data bits
    cs_lo; tx_byte(8'h0B); tx_addr(32'h0000_0101, 1'b0, 1'b0);
    repeat (8) cyc(4'h0, d, o);
    repeat (3) cyc(4'h0, d, o);
    chk("busy_active", busy_out, 1);
    cs_n_in = 1'b1;
    clk_n(4);
    chk("abort_oe", io_oe, 0);
    chk("abort_busy", busy_out, 0);
    clk_n(8);
    do_read(8'h0B, 32'h0000_0101, 1);

    for (int it = 0; it < 24; it++) begin
      r    = $urandom;
      kind = $urandom_range(0, 5);
      a    = {r[31:16], 16'($urandom_range(0, 16'h01FB))};
      case (kind)
        0: do_read(r[0] ? 8'h0C : 8'h0B, a, $urandom_range(1, 4));
        1: do_read(r[0] ? 8'hEC : 8'hEB, a, $urandom_range(1, 4));
        2, 5: begin
          if (r[1]) do_simple(8'h06);
          if (kind == 2) op = r[0] ? 8'h12 : 8'h02;
          else           op = r[0] ? 8'h34 : 8'h32;
          do_prog(op, a, $urandom_range(1, 4), $urandom);
          do_read(8'h0B, {16'h0, a[15:8], 8'h00}, 0);
          do_read(8'h0B, {16'h0, a[15:0]}, 1);
        end
        3: do_status($urandom_range(1, 2));
        default: begin
          do_simple(r[0] ? 8'hB7 : 8'hE9);
          chk("addr4b_rand", addr4b_mode_out, a4b_m);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
